// File: rtl/slave_ram_model.sv
// Memory-backed slave endpoint for one crossbar slave port.
// Word-addressed RAM with a fixed number of wait states between request
// acceptance and the single-cycle ack. Handshake: the master raises req with
// addr/cmd/wdata and holds it until ack. The fields are sampled only at the
// accepting edge in IDLE. ack pulses for exactly one cycle. busy covers the
// span from acceptance through the ack cycle, and also the post-reset clear.
module slave_ram_model #(
   parameter int DEPTH     = 256,
   parameter int AW        = $clog2(DEPTH),
   parameter int LATENCY   = 2,
   parameter int INIT_ZERO = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        cmd,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Final value of the wait counter before moving to RESP.
   localparam logic [3:0] WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t        state;
   state_t        state_nx;
   logic [3:0]    wait_cnt;
   logic [3:0]    wait_cnt_nx;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic          cmd_q;
   logic          busy_q;
   logic          clearing;
   logic [AW-1:0] clr_idx;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] addr_idx;
   logic          accept;
   logic          enter_resp;
   logic [AW-1:0] rd_idx;
   logic          rd_cmd;
   logic          unused_addr_bits;

   // Byte address to word index. The remaining address bits alias.
   assign addr_idx         = addr[AW+1:2];
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

   // No request is taken while the post-reset clear is still running.
   assign accept     = (state == IDLE) && req && !clearing;
   assign enter_resp = (state_nx == RESP) && (state != RESP);

   // With zero latency RESP is entered straight from IDLE, so the read index
   // and command come from the live inputs rather than the latched copies.
   assign rd_idx = (state == IDLE) ? addr_idx : idx_q;
   assign rd_cmd = (state == IDLE) ? cmd : cmd_q;

   assign ack  = (state == RESP);
   assign busy = busy_q || (clearing && rst);

   // Next-state logic and wait-state counting.
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               wait_cnt_nx = 4'd0;
               state_nx    = (LATENCY > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nx = RESP;
            end else begin
               wait_cnt_nx = wait_cnt + 4'd1;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Control registers: FSM state, request capture, busy, clear sweep and
   // read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         idx_q    <= '0;
         wdata_q  <= 32'd0;
         cmd_q    <= 1'b0;
         busy_q   <= 1'b0;
         rdata    <= 32'd0;
         clearing <= (INIT_ZERO != 0);
         clr_idx  <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         if (accept) begin
            idx_q   <= addr_idx;
            wdata_q <= wdata;
            cmd_q   <= cmd;
            busy_q  <= 1'b1;
         end else if (state == RESP) begin
            busy_q <= 1'b0;
         end
         if (clearing) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(DEPTH - 1)) begin
               clearing <= 1'b0;
            end
         end
         // Load read data on entry to RESP. Any earlier write has already
         // committed, because writes land at the end of their own RESP cycle.
         if (enter_resp && !rd_cmd) begin
            rdata <= mem[rd_idx];
         end
      end
   end

   // Storage: the clear sweep after reset, otherwise the write commit at the end of RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (clearing) begin
            mem[clr_idx] <= 32'd0;
         end else if ((state == RESP) && cmd_q) begin
            mem[idx_q] <= wdata_q;
         end
      end
   end

endmodule

// File: tb/tb_slave_ram_model.sv
// Directed bench for slave_ram_model. It uses three instances:
//   dut 0: LATENCY=2, INIT_ZERO=1
//   dut 1: LATENCY=2, INIT_ZERO=0 (reset abandoning an in-flight write)
//   dut 2: LATENCY=0, INIT_ZERO=0 (zero wait states and aliasing)
module tb_slave_ram_model;

   localparam int DEPTH = 256;

   logic        clk;
   logic        rst   [3];
   logic        req   [3];
   logic        cmd   [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic        ack   [3];
   logic        busy  [3];

   int checks;
   int errors;

   typedef struct {
      int          d;
      logic        cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic        poke;
      string       name;
   } vec_t;

   vec_t tbl[$];

   slave_ram_model #(.DEPTH(DEPTH), .LATENCY(2), .INIT_ZERO(1)) u_ram0 (
      .clk(clk), .rst(rst[0]), .req(req[0]), .addr(addr[0]), .wdata(wdata[0]),
      .cmd(cmd[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0])
   );

   slave_ram_model #(.DEPTH(DEPTH), .LATENCY(2), .INIT_ZERO(0)) u_ram1 (
      .clk(clk), .rst(rst[1]), .req(req[1]), .addr(addr[1]), .wdata(wdata[1]),
      .cmd(cmd[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1])
   );

   slave_ram_model #(.DEPTH(DEPTH), .LATENCY(0), .INIT_ZERO(0)) u_ram2 (
      .clk(clk), .rst(rst[2]), .req(req[2]), .addr(addr[2]), .wdata(wdata[2]),
      .cmd(cmd[2]), .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2])
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   function automatic void add(input int d, input logic c, input logic [31:0] a,
                               input logic [31:0] w, input logic [31:0] e,
                               input int l, input logic p, input string n);
      vec_t v;
      v.d = d; v.cmd = c; v.addr = a; v.wdata = w; v.exp_rdata = e;
      v.exp_lat = l; v.poke = p; v.name = n;
      tbl.push_back(v);
   endfunction

   // Drives one transaction, then measures latency, busy span, the ack pulse and rdata.
   task automatic run_vec(input vec_t v);
      int          lat;
      int          busy_n;
      logic [31:0] rd;
      lat    = 0;
      busy_n = 0;
      rd     = 32'd0;
      @(negedge clk);
      req[v.d]   = 1'b1;
      cmd[v.d]   = v.cmd;
      addr[v.d]  = v.addr;
      wdata[v.d] = v.wdata;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 20; k++) begin
         if (k == 1 && v.poke) begin
            addr[v.d]  = 32'h14;
            cmd[v.d]   = 1'b1;
            wdata[v.d] = 32'h0;
         end
         if (busy[v.d]) busy_n++;
         if (ack[v.d]) begin
            lat = k;
            rd  = rdata[v.d];
            break;
         end
         @(posedge clk);
         #1;
      end
      req[v.d] = 1'b0;
      check({v.name, "_lat"}, lat, v.exp_lat);
      check({v.name, "_busy_cycles"}, busy_n, v.exp_lat);
      check({v.name, "_rdata"}, rd, v.exp_rdata);
      @(posedge clk);
      #1;
      check({v.name, "_after_ack"}, {30'd0, ack[v.d], busy[v.d]}, 32'd0);
   endtask

   initial begin
      int          n;
      logic        saw;
      int          op;
      int          ack_cyc [4];
      logic [31:0] rd_b2b  [4];
      logic        b_cmd   [4];
      logic [31:0] b_addr  [4];
      logic [31:0] b_wdata [4];
      vec_t        v;

      checks = 0;
      errors = 0;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b0; req[i] = 1'b0; cmd[i] = 1'b0;
         addr[i] = 32'd0; wdata[i] = 32'd0;
      end

      // d, cmd, addr, wdata, expected rdata, expected latency, poke while busy, name
      add(0, 1'b0, 32'h000,      32'h0,        32'h0,        3, 1'b0, "rd_0x000");
      add(0, 1'b0, 32'h3FC,      32'h0,        32'h0,        3, 1'b0, "rd_0x3fc");
      add(0, 1'b0, 32'h200,      32'h0,        32'h0,        3, 1'b0, "rd_0x200");
      add(0, 1'b1, 32'h010,      32'hDEADBEEF, 32'h0,        3, 1'b0, "wr_0x10");
      add(0, 1'b0, 32'h010,      32'h0,        32'hDEADBEEF, 3, 1'b0, "rd_0x10");
      add(0, 1'b1, 32'h014,      32'h77777777, 32'hDEADBEEF, 3, 1'b0, "wr_0x14");
      add(0, 1'b0, 32'h010,      32'h0,        32'hDEADBEEF, 3, 1'b1, "rd_0x10_poked");
      add(0, 1'b0, 32'h014,      32'h0,        32'h77777777, 3, 1'b0, "rd_0x14_intact");
      add(0, 1'b0, 32'h013,      32'h0,        32'hDEADBEEF, 3, 1'b0, "rd_0x13_byteoff");
      add(0, 1'b1, 32'h3FC,      32'h12345678, 32'hDEADBEEF, 3, 1'b0, "wr_0x3fc");
      add(0, 1'b0, 32'h7FC,      32'h0,        32'h12345678, 3, 1'b0, "rd_0x7fc_alias");
      add(1, 1'b1, 32'h040,      32'h0BADF00D, 32'h0,        3, 1'b0, "d1_wr_0x40");
      add(1, 1'b0, 32'h040,      32'h0,        32'h0BADF00D, 3, 1'b0, "d1_rd_0x40");
      add(2, 1'b1, 32'h400,      32'h5A5A5A5A, 32'h0,        1, 1'b0, "d2_wr_0x400");
      add(2, 1'b0, 32'h000,      32'h0,        32'h5A5A5A5A, 1, 1'b0, "d2_rd_0x0_alias");
      add(2, 1'b1, 32'h000,      32'hA5A5A5A5, 32'h5A5A5A5A, 1, 1'b0, "d2_wr_0x0");
      add(2, 1'b0, 32'hFFFFFC00, 32'h0,        32'hA5A5A5A5, 1, 1'b0, "d2_rd_high_alias");

      // Reset state: every output is zero while reset is held.
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {31'd0, ack[0]}, 32'd0);
      check("rst_busy", {31'd0, busy[0]}, 32'd0);
      check("rst_rdata", rdata[0], 32'd0);
      check("rst_d2_rdata", rdata[2], 32'd0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) rst[i] = 1'b1;

      // Clear sweep: busy rises once reset is released and stays high for about DEPTH cycles.
      @(posedge clk);
      #1;
      check("clear_busy_high", {31'd0, busy[0]}, 32'd1);
      check("noclear_d1_busy", {31'd0, busy[1]}, 32'd0);
      n = 1;
      while (busy[0] && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("clear_cycles_in_range", {31'd0, (n >= DEPTH - 1) && (n <= DEPTH + 1)}, 32'd1);

      // Table-driven transactions.
      foreach (tbl[i]) run_vec(tbl[i]);

      // Back-to-back: req is held high across four transactions on dut 0.
      b_cmd[0] = 1'b1; b_addr[0] = 32'h20; b_wdata[0] = 32'h11111111;
      b_cmd[1] = 1'b0; b_addr[1] = 32'h20; b_wdata[1] = 32'h0;
      b_cmd[2] = 1'b1; b_addr[2] = 32'h24; b_wdata[2] = 32'h22222222;
      b_cmd[3] = 1'b0; b_addr[3] = 32'h24; b_wdata[3] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         ack_cyc[i] = 0;
         rd_b2b[i]  = 32'd0;
      end
      op = 0;
      @(negedge clk);
      req[0] = 1'b1; cmd[0] = b_cmd[0]; addr[0] = b_addr[0]; wdata[0] = b_wdata[0];
      @(posedge clk);
      for (int cyc = 1; cyc <= 24; cyc++) begin
         #1;
         if (ack[0]) begin
            ack_cyc[op] = cyc;
            rd_b2b[op]  = rdata[0];
            op++;
            if (op < 4) begin
               cmd[0] = b_cmd[op]; addr[0] = b_addr[op]; wdata[0] = b_wdata[op];
            end else begin
               req[0] = 1'b0;
            end
         end
         if (op == 4) break;
         @(posedge clk);
      end
      req[0] = 1'b0;
      for (int i = 0; i < 4; i++) check($sformatf("b2b_ack_cycle_%0d", i), ack_cyc[i], 3 + 4 * i);
      check("b2b_wr0_rdata_held", rd_b2b[0], 32'h12345678);
      check("b2b_rd_0x20", rd_b2b[1], 32'h11111111);
      check("b2b_wr2_rdata_held", rd_b2b[2], 32'h11111111);
      check("b2b_rd_0x24", rd_b2b[3], 32'h22222222);
      @(posedge clk);
      #1;
      check("b2b_idle_after", {31'd0, busy[0]}, 32'd0);

      // Reset while a write to 0x40 on dut 1 sits in WAIT: the write is abandoned.
      @(negedge clk);
      req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      check("midop_busy_in_wait", {31'd0, busy[1]}, 32'd1);
      rst[1] = 1'b0;
      @(posedge clk);
      #1;
      check("midop_rst_ack", {31'd0, ack[1]}, 32'd0);
      check("midop_rst_busy", {31'd0, busy[1]}, 32'd0);
      check("midop_rst_rdata", rdata[1], 32'd0);
      @(posedge clk);
      #1;
      check("rst_with_req_not_accepted", {31'd0, busy[1]}, 32'd0);
      @(negedge clk);
      req[1] = 1'b0;
      rst[1] = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (ack[1] || busy[1]) saw = 1'b1;
      end
      check("midop_no_ack_after", {31'd0, saw}, 32'd0);
      v.d = 1; v.cmd = 1'b0; v.addr = 32'h40; v.wdata = 32'h0;
      v.exp_rdata = 32'h0BADF00D; v.exp_lat = 3; v.poke = 1'b0; v.name = "midop_rd_0x40";
      run_vec(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/slave_ram_model.md
Name: slave_ram_model

Overview:
- Memory-backed slave endpoint on the crossbar's slave side. Attaches directly to one slave port of the 2x2 interconnect: consumes slave_N_req/addr/wdata/cmd and produces slave_N_rdata/ack.
- Provides word-addressed storage with a programmable fixed wait-state count. Serves as the reference target for interconnect integration and stress tests, and as a small on-chip RAM.

Parameters:
- DEPTH, 256, number of 32-bit words. Power of two, ≥2.
- AW, $clog2(DEPTH), word-index width. Derived; do not override.
- LATENCY, 2, wait cycles inserted between request acceptance and ack. Range 0..15.
- INIT_ZERO, 1, 1 = clear all words on reset. 0 = contents undefined after reset.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low
- req  input  1  request valid, held by master until ack
- addr  input  32  byte address. Word index = addr[AW+1:2]. Bits [1:0] and above AW+1 are ignored (aliasing).
- wdata  input  32  write data
- cmd  input  1  1 = write, 0 = read
- rdata  output  32  read data, valid in the ack cycle of a read
- ack  output  1  one-cycle completion pulse
- busy  output  1  high from acceptance until and including the ack cycle

Behaviour:
- Reset (rst=0 at a clock edge):
  - ack=0, busy=0, rdata=0, state=IDLE, wait counter=0.
  - With INIT_ZERO=1, all words are cleared. Clearing may take DEPTH cycles after rst rises; during that time busy=1 and no request is accepted.
- States IDLE, WAIT, RESP.
  - IDLE: when req=1 (and not clearing), latch addr index, cmd and wdata; busy←1. Go to WAIT if LATENCY>0, else RESP.
  - WAIT: the counter counts LATENCY cycles. On the last count go to RESP. The req/addr/cmd/wdata inputs are ignored.
  - RESP: ack=1 for exactly this cycle. Then go to IDLE; busy←0 on the next edge.
- Latency: ack is high LATENCY+1 cycles after the edge at which req was first sampled high in IDLE (LATENCY=0 gives ack in the cycle after acceptance).
- Write: the memory word at the latched index is updated at the end of the RESP cycle. rdata is unchanged on writes.
- Read:
  - rdata is loaded with mem[index] so that it is valid during the RESP cycle.
  - The value read is the memory content at RESP time, so a preceding write in an earlier transaction is always visible.
  - rdata holds its value after ack until the next read completes.
- Handshake rules:
  - Request fields are sampled only at acceptance. Changes to the inputs while busy have no effect.
  - req may drop after ack (the master de-asserts in the cycle following ack).
  - If req is still 1 in the cycle after RESP (back-to-back), that cycle is IDLE and it is a new transaction. Minimum issue interval = LATENCY+2 cycles.
  - req is assumed not to drop before ack. If it does, the accepted transaction still completes and ack still pulses.
- Reset mid-transaction: the transaction is abandoned. No write commits, no ack is produced, and all outputs take their reset values.
- Simultaneous rst=0 and req=1: reset wins and nothing is accepted.
- Address aliasing: addr = base + k·4·DEPTH maps to the same word. No error response.

Test Plan:
- Reset check: with INIT_ZERO=1, wait until busy=0. Read addr 0x0, 0x3FC and 0x200 -> rdata=0 each, ack a single-cycle pulse.
- Write then read: write 0xDEADBEEF to 0x10 -> ack exactly 3 cycles after acceptance (LATENCY=2), busy high for 3 cycles. Read 0x10 -> rdata=0xDEADBEEF on the ack cycle.
- Back-to-back: req held high continuously across 4 alternating writes/reads to 0x20/0x24 -> one ack every 4 cycles. Reads return the just-written values (0x11111111, 0x22222222).
- Input change while busy: after acceptance of a read of 0x10, drive addr=0x14, cmd=1, wdata=0 -> rdata=0xDEADBEEF and mem[0x14] is unchanged.
- Reset mid-op: assert rst during WAIT of a write of 0xCAFEF00D to 0x40 -> no ack. After reset (INIT_ZERO=0), a read of 0x40 does not return 0xCAFEF00D. Outputs are 0 during reset.
- Aliasing and LATENCY=0: with DEPTH=256, write 0x5A5A5A5A to 0x400, then read 0x0 -> rdata=0x5A5A5A5A, ack 1 cycle after acceptance.
